// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS core: ALU opcodes, register constants
// and the ID/EX control payload.
package mips_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       use_imm;
    logic [1:0] alu_op;
  } ex_ctrl_t;

  localparam ex_ctrl_t EX_CTRL_BUBBLE = '{
    valid:     1'b0,
    reg_write: 1'b0,
    mem_read:  1'b0,
    mem_write: 1'b0,
    use_imm:   1'b0,
    alu_op:    ALU_ADD
  };

endpackage : mips_pkg

// File: rtl/fwd_mux.sv
// Operand bypass select: EX/MEM result beats MEM/WB data beats the captured
// register value; writes to $0 never match.
module fwd_mux #(
  parameter int unsigned DATA_W = mips_pkg::DATA_W,
  parameter int unsigned REG_AW = mips_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] i_src_addr,
  input  logic [DATA_W-1:0] i_reg_data,
  input  logic              i_exm_reg_write,
  input  logic [REG_AW-1:0] i_exm_rd_addr,
  input  logic [DATA_W-1:0] i_exm_result,
  input  logic              i_wb_reg_write,
  input  logic [REG_AW-1:0] i_wb_rd_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  output logic [DATA_W-1:0] o_fwd_data_c
);
  import mips_pkg::*;

  logic w_exm_hit;
  logic w_wb_hit;

  assign w_exm_hit = i_exm_reg_write && (i_exm_rd_addr != REG_AW'(REG_ZERO))
                     && (i_exm_rd_addr == i_src_addr);
  assign w_wb_hit  = i_wb_reg_write && (i_wb_rd_addr != REG_AW'(REG_ZERO))
                     && (i_wb_rd_addr == i_src_addr);

  always_comb begin
    o_fwd_data_c = i_reg_data;
    if (w_exm_hit) begin
      o_fwd_data_c = i_exm_result;
    end else if (w_wb_hit) begin
      o_fwd_data_c = i_wb_data;
    end
  end

endmodule : fwd_mux

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, capture-time write-back
// bypass and load-use bubble insertion.
module id_ex_stage #(
  parameter int unsigned DATA_W = mips_pkg::DATA_W,
  parameter int unsigned REG_AW = mips_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_use_imm,
  input  logic              id_use_rt,
  input  logic [1:0]        id_alu_op,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              flush,
  input  logic              exm_reg_write,
  input  logic [REG_AW-1:0] exm_rd_addr,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] ex_data1,
  output logic [DATA_W-1:0] ex_data2,
  output logic [1:0]        ex_alu_op,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_rd_addr,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              stall_id
);
  import mips_pkg::*;

  ex_ctrl_t          r_ctrl;
  logic [REG_AW-1:0] r_rs_addr;
  logic [REG_AW-1:0] r_rt_addr;
  logic [REG_AW-1:0] r_rd_addr;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;

  logic              w_load_use;
  logic              w_bubble;
  logic              w_wb_rs_hit;
  logic              w_wb_rt_hit;
  logic [DATA_W-1:0] w_rs_cap;
  logic [DATA_W-1:0] w_rt_cap;
  logic [DATA_W-1:0] w_rs_fwd;
  logic [DATA_W-1:0] w_rt_fwd;
  ex_ctrl_t          w_id_ctrl;

  // Load in EX whose destination is read by the instruction in ID.
  assign w_load_use = r_ctrl.valid && r_ctrl.mem_read && id_valid
                      && (r_rd_addr != REG_AW'(REG_ZERO))
                      && ((r_rd_addr == id_rs_addr)
                          || (id_use_rt && (r_rd_addr == id_rt_addr)));
  assign stall_id   = w_load_use && !flush;
  assign w_bubble   = flush || w_load_use;

  // Write-back lands in the register file this same cycle, so take it directly.
  assign w_wb_rs_hit = wb_reg_write && (wb_rd_addr != REG_AW'(REG_ZERO))
                       && (wb_rd_addr == id_rs_addr);
  assign w_wb_rt_hit = wb_reg_write && (wb_rd_addr != REG_AW'(REG_ZERO))
                       && (wb_rd_addr == id_rt_addr);
  assign w_rs_cap    = w_wb_rs_hit ? wb_data : id_rs_data;
  assign w_rt_cap    = w_wb_rt_hit ? wb_data : id_rt_data;

  assign w_id_ctrl = '{
    valid:     id_valid,
    reg_write: id_reg_write,
    mem_read:  id_mem_read,
    mem_write: id_mem_write,
    use_imm:   id_use_imm,
    alu_op:    id_alu_op
  };

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl    <= EX_CTRL_BUBBLE;
      r_rs_addr <= '0;
      r_rt_addr <= '0;
      r_rd_addr <= '0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm     <= '0;
    end else if (w_bubble) begin
      r_ctrl    <= EX_CTRL_BUBBLE;
      r_rs_addr <= '0;
      r_rt_addr <= '0;
      r_rd_addr <= '0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm     <= '0;
    end else begin
      r_ctrl    <= w_id_ctrl;
      r_rs_addr <= id_rs_addr;
      r_rt_addr <= id_rt_addr;
      r_rd_addr <= id_rd_addr;
      r_rs_data <= w_rs_cap;
      r_rt_data <= w_rt_cap;
      r_imm     <= id_imm;
    end
  end

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
    .i_src_addr      (r_rs_addr),
    .i_reg_data      (r_rs_data),
    .i_exm_reg_write (exm_reg_write),
    .i_exm_rd_addr   (exm_rd_addr),
    .i_exm_result    (exm_result),
    .i_wb_reg_write  (wb_reg_write),
    .i_wb_rd_addr    (wb_rd_addr),
    .i_wb_data       (wb_data),
    .o_fwd_data_c    (w_rs_fwd)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
    .i_src_addr      (r_rt_addr),
    .i_reg_data      (r_rt_data),
    .i_exm_reg_write (exm_reg_write),
    .i_exm_rd_addr   (exm_rd_addr),
    .i_exm_result    (exm_result),
    .i_wb_reg_write  (wb_reg_write),
    .i_wb_rd_addr    (wb_rd_addr),
    .i_wb_data       (wb_data),
    .o_fwd_data_c    (w_rt_fwd)
  );

  assign ex_data1      = w_rs_fwd;
  assign ex_data2      = r_ctrl.use_imm ? r_imm : w_rt_fwd;
  assign ex_store_data = w_rt_fwd;
  assign ex_alu_op     = r_ctrl.alu_op;
  assign ex_rd_addr    = r_rd_addr;
  assign ex_valid      = r_ctrl.valid;
  assign ex_reg_write  = r_ctrl.reg_write;
  assign ex_mem_read   = r_ctrl.mem_read;
  assign ex_mem_write  = r_ctrl.mem_write;

endmodule : id_ex_stage

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, forwarding priority, load-use bubble,
// flush interaction, $0 suppression and capture-time bypass.
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_use_imm, id_use_rt;
  logic [1:0]  id_alu_op;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic        flush;
  logic        exm_reg_write;
  logic [4:0]  exm_rd_addr;
  logic [31:0] exm_result;
  logic        wb_reg_write;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_data;
  logic [31:0] ex_data1, ex_data2, ex_store_data;
  logic [1:0]  ex_alu_op;
  logic [4:0]  ex_rd_addr;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic        stall_id;

  int n_checks;
  int n_errors;

  id_ex_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid      (id_valid),
    .id_rs_addr    (id_rs_addr),
    .id_rt_addr    (id_rt_addr),
    .id_rd_addr    (id_rd_addr),
    .id_rs_data    (id_rs_data),
    .id_rt_data    (id_rt_data),
    .id_imm        (id_imm),
    .id_use_imm    (id_use_imm),
    .id_use_rt     (id_use_rt),
    .id_alu_op     (id_alu_op),
    .id_reg_write  (id_reg_write),
    .id_mem_read   (id_mem_read),
    .id_mem_write  (id_mem_write),
    .flush         (flush),
    .exm_reg_write (exm_reg_write),
    .exm_rd_addr   (exm_rd_addr),
    .exm_result    (exm_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd_addr    (wb_rd_addr),
    .wb_data       (wb_data),
    .ex_data1      (ex_data1),
    .ex_data2      (ex_data2),
    .ex_alu_op     (ex_alu_op),
    .ex_store_data (ex_store_data),
    .ex_rd_addr    (ex_rd_addr),
    .ex_valid      (ex_valid),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .stall_id      (stall_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one cycle and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic id_clear();
    id_valid = 0; id_rs_addr = 0; id_rt_addr = 0; id_rd_addr = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_use_imm = 0; id_use_rt = 0; id_alu_op = 2'b00;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
  endtask

  task automatic prod_clear();
    exm_reg_write = 0; exm_rd_addr = 0; exm_result = 0;
    wb_reg_write = 0; wb_rd_addr = 0; wb_data = 0;
  endtask

  task automatic id_instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                          input logic use_imm, input logic use_rt, input logic [1:0] op,
                          input logic rw, input logic mr, input logic mw);
    id_valid = 1; id_rs_addr = rs; id_rt_addr = rt; id_rd_addr = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    id_use_imm = use_imm; id_use_rt = use_rt; id_alu_op = op;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 0;
    flush = 0;
    id_clear();
    prod_clear();

    // Reset state
    step();
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_data1", ex_data1, 32'd0);
    chk("rst_stall", 32'(stall_id), 32'd0);
    rst_n = 1;
    step();
    step();
    chk("idle_data1", ex_data1, 32'd0);
    chk("idle_data2", ex_data2, 32'd0);
    chk("idle_store", ex_store_data, 32'd0);
    chk("idle_alu_op", 32'(ex_alu_op), 32'd0);
    chk("idle_rd", 32'(ex_rd_addr), 32'd0);
    chk("idle_ctrl", {28'd0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write}, 32'd0);
    chk("idle_stall", 32'(stall_id), 32'd0);

    // add $3,$1,$2
    id_instr(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 0, 1, 2'b00, 1, 0, 0);
    step();
    chk("add_data1", ex_data1, 32'd5);
    chk("add_data2", ex_data2, 32'd7);
    chk("add_rd", 32'(ex_rd_addr), 32'd3);
    chk("add_valid_rw", {30'd0, ex_valid, ex_reg_write}, 32'd3);

    // sub $4,$3,$1 with add in EX/MEM
    id_instr(5'd3, 5'd1, 5'd4, 32'hDEAD_BEEF, 32'd5, 32'd0, 0, 1, 2'b01, 1, 0, 0);
    step();
    exm_reg_write = 1; exm_rd_addr = 5'd3; exm_result = 32'h0000_0010;
    #1;
    chk("sub_fwd_exm", ex_data1, 32'h0000_0010);
    chk("sub_data2", ex_data2, 32'd5);
    chk("sub_alu_op", 32'(ex_alu_op), 32'd1);

    // Both producers target $3: EX/MEM wins, then MEM/WB alone
    exm_result = 32'hAAAA_0000;
    wb_reg_write = 1; wb_rd_addr = 5'd3; wb_data = 32'h5555_0000;
    #1;
    chk("prio_exm", ex_data1, 32'hAAAA_0000);
    exm_reg_write = 0;
    #1;
    chk("prio_wb", ex_data1, 32'h5555_0000);
    prod_clear();

    // lw $5,0($0) then or $6,$5,$1
    id_instr(5'd0, 5'd5, 5'd5, 32'd0, 32'd0, 32'd0, 1, 0, 2'b00, 1, 1, 0);
    step();
    chk("lw_mem_read", 32'(ex_mem_read), 32'd1);
    id_instr(5'd5, 5'd1, 5'd6, 32'h0000_0BAD, 32'h0000_000F, 32'd0, 0, 1, 2'b10, 1, 0, 0);
    #1;
    chk("lu_stall", 32'(stall_id), 32'd1);
    step();
    chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
    chk("lu_bubble_rd", 32'(ex_rd_addr), 32'd0);
    chk("lu_stall_drop", 32'(stall_id), 32'd0);
    step();
    wb_reg_write = 1; wb_rd_addr = 5'd5; wb_data = 32'h1234_5678;
    #1;
    chk("lu_fwd_wb", ex_data1, 32'h1234_5678);
    chk("lu_or_data2", ex_data2, 32'h0000_000F);
    chk("lu_or_op", 32'(ex_alu_op), 32'd2);
    chk("lu_or_valid", 32'(ex_valid), 32'd1);
    prod_clear();

    // lw $7, then a consumer of $7 via rt only
    id_instr(5'd0, 5'd7, 5'd7, 32'd0, 32'd0, 32'd4, 1, 0, 2'b00, 1, 1, 0);
    step();
    id_instr(5'd2, 5'd7, 5'd8, 32'd1, 32'd2, 32'd0, 0, 0, 2'b00, 1, 0, 0);
    #1;
    chk("lu_rt_unused", 32'(stall_id), 32'd0);
    id_use_rt = 1;
    #1;
    chk("lu_rt_used", 32'(stall_id), 32'd1);
    flush = 1;
    #1;
    chk("lu_flush_stall", 32'(stall_id), 32'd0);
    step();
    flush = 0;
    chk("lu_flush_valid", 32'(ex_valid), 32'd0);

    // $0 producers never forward
    id_instr(5'd0, 5'd0, 5'd9, 32'd0, 32'd0, 32'd0, 0, 1, 2'b00, 1, 0, 0);
    step();
    exm_reg_write = 1; exm_rd_addr = 5'd0; exm_result = 32'hFFFF_FFFF;
    wb_reg_write = 1; wb_rd_addr = 5'd0; wb_data = 32'hEEEE_EEEE;
    #1;
    chk("zero_data1", ex_data1, 32'd0);
    chk("zero_data2", ex_data2, 32'd0);
    prod_clear();

    // Capture-time MEM/WB bypass on rt with immediate operand (store)
    id_instr(5'd1, 5'd9, 5'd0, 32'h11, 32'h99, 32'h44, 1, 1, 2'b00, 0, 0, 1);
    wb_reg_write = 1; wb_rd_addr = 5'd9; wb_data = 32'hCAFE_F00D;
    step();
    prod_clear();
    #1;
    chk("cap_data1", ex_data1, 32'h11);
    chk("cap_data2_imm", ex_data2, 32'h44);
    chk("cap_store", ex_store_data, 32'hCAFE_F00D);
    chk("cap_mem_write", 32'(ex_mem_write), 32'd1);

    // Reset asserted during a load-use stall
    id_instr(5'd0, 5'd10, 5'd10, 32'd0, 32'd0, 32'd0, 1, 0, 2'b00, 1, 1, 0);
    step();
    id_instr(5'd10, 5'd0, 5'd11, 32'd0, 32'd0, 32'd0, 0, 0, 2'b00, 1, 0, 0);
    #1;
    chk("rst_mid_pre", 32'(stall_id), 32'd1);
    rst_n = 0;
    #1;
    chk("rst_mid_stall", 32'(stall_id), 32'd0);
    chk("rst_mid_valid", 32'(ex_valid), 32'd0);
    chk("rst_mid_rd", 32'(ex_rd_addr), 32'd0);
    step();
    rst_n = 1;
    id_clear();
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_id_ex_stage

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register and operand-forwarding unit for the 5-stage MIPS core. It captures decoded operands and control from ID and resolves RAW hazards by bypassing from EX/MEM and MEM/WB. It detects load-use hazards and inserts a bubble, and drives the ALU's `data1`, `data2` and `alu_op` inputs directly.

## Interface
- `DATA_W`, 32: datapath width.
- `REG_AW`, 5: register address width.

- `clk`  in  1  core clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  ID holds a real instruction.
- `id_rs_addr`, `id_rt_addr`, `id_rd_addr`  in  REG_AW  source and destination register numbers. `id_rd_addr` is the already-selected write target.
- `id_rs_data`, `id_rt_data`  in  DATA_W  register-file read data.
- `id_imm`  in  DATA_W  sign- or zero-extended immediate.
- `id_use_imm`, `id_use_rt`  in  1  `id_use_imm` selects the immediate as operand 2; `id_use_rt` marks `rt` as a true source.
- `id_alu_op`  in  2  ALU opcode: 00 add, 01 sub, 10 or.
- `id_reg_write`, `id_mem_read`, `id_mem_write`  in  1  control flags.
- `flush`  in  1  kill the instruction entering EX (taken branch or exception).
- `exm_reg_write`, `exm_rd_addr`, `exm_result`  in  1/REG_AW/DATA_W  EX/MEM producer.
- `wb_reg_write`, `wb_rd_addr`, `wb_data`  in  1/REG_AW/DATA_W  MEM/WB producer. This is also the register-file write port.
- `ex_data1`, `ex_data2`  out  DATA_W  ALU operands, after forwarding.
- `ex_alu_op`  out  2  registered opcode.
- `ex_store_data`  out  DATA_W  forwarded `rt` value, used for stores.
- `ex_rd_addr`  out  REG_AW  registered destination.
- `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`  out  1  registered control.
- `stall_id`  out  1  combinational; holds the PC and the IF/ID register.

## Operation
- **Registered fields:** rs/rt/rd addresses, rs/rt data, imm, use_imm, alu_op, valid, and the three control flags.
- **Capture bypass:**
  - If `wb_reg_write` is set, `wb_rd_addr` ≠ 0 and it equals the rs (or rt) address, `wb_data` is captured instead of the register-file data.
  - This covers the three-ahead dependency.
- **EX forwarding:** applied to the registered rs value (and likewise rt), first matching rule wins:
  1. `exm_reg_write` set, `exm_rd_addr` ≠ 0, and it equals the rs address → `exm_result`.
  2. `wb_reg_write` set, `wb_rd_addr` ≠ 0, and it equals the rs address → `wb_data`.
  3. Otherwise → the captured register value.
- **Operand drive:**
  - `ex_data1` = forwarded rs.
  - `ex_data2` = `id_use_imm`(registered) ? imm : forwarded rt.
  - `ex_store_data` = forwarded rt, always.
- **Load-use hazard:** asserted when all of the following hold:
  - `ex_valid`, `ex_mem_read` and `id_valid` are set;
  - `ex_rd_addr` ≠ 0;
  - `ex_rd_addr` equals `id_rs_addr`, or equals `id_rt_addr` with `id_use_rt` set.
- **Stall output:** `stall_id` = load_use & ~`flush`.
- **Next-state selection** (priority order):
  1. `flush` → bubble.
  2. load_use → bubble.
  3. Otherwise → capture the ID fields.
- **Bubble:**
  - `ex_valid`, `ex_reg_write`, `ex_mem_read` and `ex_mem_write` are cleared.
  - Addresses are cleared to 0, so no forwarding match is possible.
  - Data, imm and alu_op are don't-care; they are cleared to 0 for determinism.
- **Arithmetic:** none. Widths pass through unchanged; no sign handling here.

## Timing
- **Reset (async assert, sync release):**
  - All registers are 0.
  - `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write` = 0.
  - `ex_alu_op` = 00; `ex_rd_addr` = 0.
  - `ex_data1` = `ex_data2` = `ex_store_data` = 0. The rs/rt addresses are 0, so forwarding is suppressed.
  - `stall_id` = 0.
- **Latency:** ID to EX is 1 cycle. Forwarding muxes are combinational within EX. `stall_id` is valid in the same cycle as the hazard.
- **Load-use:** costs exactly one bubble cycle. On the next cycle the load is in MEM/WB and rule 2 supplies the loaded data.
- **Flush + load_use in the same cycle:** bubble inserted, `stall_id` = 0, and the ID instruction is discarded upstream.
- **Reset asserted mid-stall:** all state is cleared immediately and `stall_id` drops.
- **`$0` writes:** never forwarded, even when `reg_write` is set.

## Structure
- Shared `mips_pkg` holds:
  - `ALU_ADD` = 2'b00, `ALU_SUB` = 2'b01, `ALU_OR` = 2'b10;
  - `REG_ZERO` = 5'd0;
  - `DATA_W` and `REG_AW` defaults.
- Sub-module `fwd_mux` holds the rule 1/2/3 selection. It is instantiated twice, for rs and rt.

## Test plan
- Release reset with no instructions → all outputs 0, `stall_id` 0.
- `add $3,$1,$2` then `sub $4,$3,$1`, with `exm_result` = 0x0000_0010 → `ex_data1` = 0x10 for the sub.
- Same `$3` pending in both stages: EX/MEM = 0xAAAA_0000, MEM/WB = 0x5555_0000 → EX/MEM value wins.
- `lw $5,0($0)`, then `or $6,$5,$1` in ID → `stall_id` = 1 for one cycle and a bubble enters EX (`ex_valid` = 0). Next cycle, forwarding from MEM/WB with `wb_data` = 0x1234_5678 → `ex_data1` = 0x1234_5678.
- Load-use hazard together with `flush` = 1 → `stall_id` = 0 and the next `ex_valid` = 0.
- `exm_rd_addr` = 0 with `exm_reg_write` = 1, and a consumer of `$0` → `ex_data1` = 0. Separately, a capture-time MEM/WB write to `rt` with `id_use_imm` = 1 → `ex_data2` = imm and `ex_store_data` = `wb_data`.
